aer_fs_sequencer: RTL and testbench

Clocked, parametrised successor to the asynchronous Fs control-signal generator in the Address Event Controller. It drives a request line to the AER receiver, waits for ack in 2-phase or 4-phase protocol, and advances a Gray-coded Fs control word by one step per completed handshake. Adds ack synchronisation, a handshake timeout with sticky error, and wrap/step status for the controller FSM above it.

---
 rtl/aer_fs_pkg.sv | 27 ++
 rtl/aer_sync.sv | 30 +++
 rtl/aer_fs_sequencer.sv | 165 ++++++++++++++++
 tb/tb_aer_fs_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_fs_pkg.sv
// -----------------------------------------------------------------------------
// aer_fs_pkg
// Shared definitions for the Fs control-word sequencer:
//   state_t    - handshake FSM states (IDLE, REQ, REL, ADV, ERR)
//   MODE_4PH   - return-to-zero handshake (req/ack pulse high then low)
//   MODE_2PH   - non-return-to-zero handshake (every req edge is a request)
//   bin2gray() - reflected binary to Gray conversion
// -----------------------------------------------------------------------------
package aer_fs_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    REL  = 3'd2,
    ADV  = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic MODE_4PH = 1'b0;
  localparam logic MODE_2PH = 1'b1;

  // 32-bit wide so any PHASE_BITS up to 32 can use it; callers truncate.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/aer_sync.sv
// -----------------------------------------------------------------------------
// aer_sync
// Multi-flop synchroniser for a single asynchronous level.
//   clk   - destination clock
//   reset - synchronous, active-high; clears every stage to 0
//   d     - asynchronous input
//   q     - d delayed by STAGES rising edges of clk
// -----------------------------------------------------------------------------
module aer_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/aer_fs_sequencer.sv
// -----------------------------------------------------------------------------
// aer_fs_sequencer
// Drives a request to the AER receiver, waits for the acknowledge in 4-phase
// or 2-phase protocol and advances a Gray-coded Fs control word by one step
// per completed handshake. Handshake waits are bounded by a programmable
// timeout that lands in a sticky error state.
//
// Ports
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   enable         - start/continue handshakes while high (sampled in IDLE)
//   mode           - 0 = 4-phase, 1 = 2-phase; latched when a handshake starts
//   ack            - asynchronous acknowledge (synchronised internally)
//   timeout_limit  - cycles allowed per ack wait, 0 = no timeout
//   clear_err      - leave ERR state
//   req            - request to receiver
//   fs_code        - Gray-coded Fs control word
//   busy           - high in REQ, REL, ADV
//   step_done      - 1-cycle pulse coincident with the fs_code update
//   wrap           - 1-cycle pulse with step_done when the word returns to 0
//   err            - sticky timeout flag
//   state_dbg      - current FSM state, for observation only
//
// Handshake semantics: a request is outstanding from the req edge until the
// synchronised ack matches it (4-phase: ack high, then ack low in REL;
// 2-phase: ack level equal to req). fs_code only moves after the full
// handshake, so the receiver never sees a word change mid-transfer.
// -----------------------------------------------------------------------------
module aer_fs_sequencer
  import aer_fs_pkg::*;
#(
  parameter int PHASE_BITS  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  ack,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  input  logic                  clear_err,
  output logic                  req,
  output logic [PHASE_BITS-1:0] fs_code,
  output logic                  busy,
  output logic                  step_done,
  output logic                  wrap,
  output logic                  err,
  output state_t                state_dbg
);

  localparam logic [TIMEOUT_W-1:0]  T_ONE = TIMEOUT_W'(1);
  localparam logic [PHASE_BITS-1:0] B_ONE = PHASE_BITS'(1);

  state_t                state;
  logic                  mode_q;
  logic [PHASE_BITS-1:0] bin;
  logic [TIMEOUT_W-1:0]  tcnt;
  logic                  ack_s;

  logic [PHASE_BITS-1:0] bin_next;
  logic [PHASE_BITS-1:0] fs_next;
  logic                  req_done;
  logic                  rel_done;
  logic                  timeout_hit;

  aer_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack),
    .q     (ack_s)
  );

  assign bin_next = bin + B_ONE;
  assign fs_next  = PHASE_BITS'(bin2gray(32'(bin_next)));

  // 2-phase: the receiver answers by copying req, so equality means done.
  assign req_done = (mode_q == MODE_4PH) ? ack_s : (ack_s == req);
  assign rel_done = ~ack_s;

  // Fires on the last allowed waiting cycle; a completion in the same cycle
  // is checked first in the FSM and therefore wins.
  assign timeout_hit = (timeout_limit != '0) && (tcnt == (timeout_limit - T_ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req       <= 1'b0;
      fs_code   <= '0;
      bin       <= '0;
      tcnt      <= '0;
      step_done <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      mode_q    <= MODE_4PH;
    end else begin
      step_done <= 1'b0;
      wrap      <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= REQ;
            mode_q <= mode;
            req    <= (mode == MODE_2PH) ? ~req : 1'b1;
            tcnt   <= '0;
          end
        end

        REQ: begin
          if (req_done) begin
            if (mode_q == MODE_4PH) begin
              state <= REL;
              req   <= 1'b0;
              tcnt  <= '0;
            end else begin
              state <= ADV;
            end
          end else if (timeout_hit) begin
            state <= ERR;
            err   <= 1'b1;
            if (mode_q == MODE_4PH) req <= 1'b0;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end

        REL: begin
          if (rel_done) begin
            state <= ADV;
          end else if (timeout_hit) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end

        ADV: begin
          bin       <= bin_next;
          fs_code   <= fs_next;
          step_done <= 1'b1;
          wrap      <= (bin_next == '0);
          state     <= IDLE;
        end

        ERR: begin
          if (clear_err) begin
            state <= IDLE;
            err   <= 1'b0;
            // Re-align req with the receiver's current level so the next
            // 2-phase request is a genuine edge relative to ack.
            if (mode_q == MODE_2PH) req <= ack_s;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE) && (state != ERR);
  assign state_dbg = state;

endmodule

// File: tb/tb_aer_fs_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aer_fs_sequencer
// Directed bench for aer_fs_sequencer (PHASE_BITS=2, SYNC_STAGES=2,
// TIMEOUT_W=8). A responder echoes req onto ack after a programmable delay,
// which covers both 4-phase and 2-phase receivers. Expected Fs words come
// from a step-index model (n -> n ^ (n >> 1)) pushed into exp_q; a per-cycle
// compare process pops one entry per step_done pulse.
// -----------------------------------------------------------------------------
module tb_aer_fs_sequencer;
  import aer_fs_pkg::*;

  localparam int W = 2;
  localparam int N_STEPS = 1 << W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         enable;
  logic         mode;
  logic         ack;
  logic [7:0]   timeout_limit;
  logic         clear_err;
  logic         req;
  logic [W-1:0] fs_code;
  logic         busy;
  logic         step_done;
  logic         wrap;
  logic         err;
  state_t       state_dbg;

  aer_fs_sequencer #(
    .PHASE_BITS  (W),
    .SYNC_STAGES (2),
    .TIMEOUT_W   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .ack           (ack),
    .timeout_limit (timeout_limit),
    .clear_err     (clear_err),
    .req           (req),
    .fs_code       (fs_code),
    .busy          (busy),
    .step_done     (step_done),
    .wrap          (wrap),
    .err           (err),
    .state_dbg     (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Settled sampling point: after the compare process at the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int model_n = 0;

  task automatic expect_steps(input int n);
    for (int i = 0; i < n; i++) begin
      model_n = (model_n + 1) % N_STEPS;
      exp_q.push_back(W'(model_n ^ (model_n >> 1)));
    end
  endtask

  int step_cnt = 0;
  int wrap_cnt = 0;
  int req_tog  = 0;
  int err_rise = 0;
  logic [W-1:0] prev_fs = '0;
  logic prev_req = 1'b0;
  logic prev_err = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_fs  = '0;
      prev_req = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (step_done) begin
        logic [W-1:0] e;
        step_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_step", 32'(fs_code), 32'(prev_fs));
          e = fs_code;
        end else begin
          e = exp_q.pop_front();
          check("fs_step", 32'(fs_code), 32'(e));
        end
        check("wrap_on_step", 32'(wrap), 32'(e == '0));
        check("gray_one_bit", $countones(fs_code ^ prev_fs), 1);
        if (wrap) wrap_cnt++;
      end else begin
        check("fs_hold", 32'(fs_code), 32'(prev_fs));
        check("wrap_idle", 32'(wrap), 0);
      end
      if (err) check("busy_in_err", 32'(busy), 0);
      if (req != prev_req) req_tog++;
      if (err && !prev_err) err_rise++;
      prev_fs  = fs_code;
      prev_req = req;
      prev_err = err;
    end
  end

  // ---------------- responder ----------------
  logic [511:0] hist = '0;
  int  resp_d  = 3;
  bit  resp_on = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      hist = {hist[510:0], req};
      if (resp_on) ack = hist[resp_d];
    end
  end

  task automatic set_resp(input bit on, input int d);
    hist    = {512{req}};
    resp_d  = d;
    resp_on = on;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_steps(input int n, input int budget, input string name);
    int target;
    int k;
    target = step_cnt + n;
    k = 0;
    enable = 1'b1;
    while (step_cnt < target && k < budget) begin
      tick();
      k++;
    end
    enable = 1'b0;
    check(name, step_cnt, target);
  endtask

  task automatic poll_state(input state_t s, input int budget, input string name);
    int k;
    k = 0;
    while (state_dbg != s && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(state_dbg), 32'(s));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, step_cnt=%0d", step_cnt);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int s0, w0, t0, e0, t_req, t_err, k;
  logic [W-1:0] fs_before;

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; ack = 1'b0;
    timeout_limit = 8'd0; clear_err = 1'b0;
    tick(); tick(); tick();

    check("rst_req",   32'(req), 0);
    check("rst_fs",    32'(fs_code), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_step",  32'(step_done), 0);
    check("rst_wrap",  32'(wrap), 0);
    check("rst_err",   32'(err), 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Test 1: 4-phase, ack 3 cycles after req, 4 steps: 01,11,10,00.
    mode = 1'b0; timeout_limit = 8'd0;
    set_resp(1'b1, 3);
    s0 = step_cnt; w0 = wrap_cnt;
    expect_steps(4);
    run_steps(4, 200, "t1_steps");
    check("t1_step_cnt", step_cnt - s0, 4);
    check("t1_wraps", wrap_cnt - w0, 1);
    check("t1_fs_final", 32'(fs_code), 32'h0);
    check("t1_err", 32'(err), 0);

    // Test 2: 2-phase, ack mirrors req after 2 cycles, 8 steps.
    mode = 1'b1;
    set_resp(1'b1, 2);
    s0 = step_cnt; w0 = wrap_cnt; t0 = req_tog;
    expect_steps(8);
    run_steps(8, 300, "t2_steps");
    check("t2_step_cnt", step_cnt - s0, 8);
    check("t2_req_toggles", req_tog - t0, 8);
    check("t2_wraps", wrap_cnt - w0, 2);
    check("t2_fs_final", 32'(fs_code), 32'h0);

    // Test 3: timeout_limit=5 with ack held low.
    mode = 1'b0; timeout_limit = 8'd5;
    set_resp(1'b0, 3);
    ack = 1'b0;
    fs_before = fs_code;
    tick();
    enable = 1'b1;
    k = 0;
    while (!req && k < 10) begin tick(); k++; end
    t_req = cyc;
    enable = 1'b0;
    check("t3_req_rose", 32'(req), 1);
    k = 0;
    while (!err && k < 20) begin tick(); k++; end
    t_err = cyc;
    check("t3_err", 32'(err), 1);
    check("t3_err_latency", t_err - t_req, 5);
    check("t3_state_err", 32'(state_dbg), 32'(ERR));
    check("t3_req_low", 32'(req), 0);
    check("t3_fs_frozen", 32'(fs_code), 32'(fs_before));
    check("t3_busy", 32'(busy), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t3_err_cleared", 32'(err), 0);
    check("t3_state_idle", 32'(state_dbg), 32'(IDLE));
    timeout_limit = 8'd20;
    set_resp(1'b1, 3);
    for (int i = 0; i < 4; i++) tick();
    s0 = step_cnt;
    expect_steps(1);
    run_steps(1, 100, "t3_recover_step");
    check("t3_fs_after", 32'(fs_code), 32'h1);
    check("t3_no_new_err", 32'(err), 0);

    // Test 4: no timeout, ack delayed 300 cycles.
    timeout_limit = 8'd0;
    set_resp(1'b1, 300);
    s0 = step_cnt; e0 = err_rise;
    expect_steps(1);
    run_steps(1, 1000, "t4_slow_step");
    check("t4_one_step", step_cnt - s0, 1);
    check("t4_no_err", err_rise - e0, 0);
    check("t4_fs", 32'(fs_code), 32'h3);

    // Test 5: enable dropped in REQ, mode flipped in REL.
    mode = 1'b0;
    set_resp(1'b1, 3);
    s0 = step_cnt;
    expect_steps(1);
    enable = 1'b1;
    poll_state(REQ, 5, "t5_in_req");
    enable = 1'b0;
    poll_state(REL, 30, "t5_in_rel");
    mode = 1'b1;
    k = 0;
    while (step_cnt == s0 && k < 30) begin tick(); k++; end
    for (int i = 0; i < 10; i++) tick();
    check("t5_one_step", step_cnt - s0, 1);
    check("t5_idle", 32'(state_dbg), 32'(IDLE));
    check("t5_req_low", 32'(req), 0);
    check("t5_fs", 32'(fs_code), 32'h2);
    // Next start uses the new (2-phase) mode: one req edge per step.
    set_resp(1'b1, 2);
    s0 = step_cnt; w0 = wrap_cnt; t0 = req_tog;
    expect_steps(2);
    run_steps(2, 100, "t5_2ph_steps");
    check("t5_2ph_toggles", req_tog - t0, 2);
    check("t5_2ph_wrap", wrap_cnt - w0, 1);
    check("t5_2ph_fs", 32'(fs_code), 32'h1);
    check("t5_2ph_req", 32'(req), 0);

    // Test 6: reset while in REL with ack high.
    mode = 1'b0;
    set_resp(1'b1, 3);
    expect_steps(1);
    enable = 1'b1;
    poll_state(REL, 30, "t6_in_rel");
    check("t6_ack_high", 32'(ack), 1);
    reset = 1'b1;
    enable = 1'b0;
    tick();
    check("t6_req", 32'(req), 0);
    check("t6_fs", 32'(fs_code), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_err", 32'(err), 0);
    check("t6_state", 32'(state_dbg), 32'(IDLE));
    model_n = 0;
    exp_q.delete();
    reset = 1'b0;
    s0 = step_cnt;
    for (int i = 0; i < 10; i++) tick();
    check("t6_stay_idle", 32'(state_dbg), 32'(IDLE));
    check("t6_req_stays_low", 32'(req), 0);
    check("t6_no_step", step_cnt - s0, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
